goal_referee: RTL and testbench

- Consumer end of the ball controller's position interface.
- Each cycle it samples ball_x/ball_y, detects entry into any of the six goal hoops, and keeps per-team scores.
- Drives game_over back to the ball controller and declares a winner at WIN_SCORE.
- Sits between the ball controller and the score display / VGA overlay.

---
 rtl/goal_referee.sv | 145 ++++++++++++++
 tb/tb_goal_referee.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/goal_referee.sv
// rtl/goal_referee.sv - goal hoop detection, per-team scoring and match control
module goal_referee #(
    parameter int BALL_RADIUS = 10,
    parameter int GOAL_RADIUS = 30,
    parameter int GOAL_Y_RED  = 100,
    parameter int GOAL_Y_BLUE = 450,
    parameter int GOAL_X0     = 300,
    parameter int GOAL_X1     = 400,
    parameter int GOAL_X2     = 500,
    parameter int WIN_SCORE   = 5,
    parameter int HOLD_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] ball_x,
    input  logic [9:0] ball_y,
    input  logic       game_on,
    input  logic       new_game,
    output logic [3:0] score_team1,
    output logic [3:0] score_team2,
    output logic       goal_team1,
    output logic       goal_team2,
    output logic       game_over,
    output logic [1:0] winner
);
    localparam logic [22:0] THRESH =
        23'((GOAL_RADIUS - BALL_RADIUS) * (GOAL_RADIUS - BALL_RADIUS));
    localparam int              CW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0]   HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [3:0]      WIN       = 4'(WIN_SCORE);
    localparam logic signed [10:0] X0 = 11'(GOAL_X0);
    localparam logic signed [10:0] X1 = 11'(GOAL_X1);
    localparam logic signed [10:0] X2 = 11'(GOAL_X2);
    localparam logic signed [10:0] YR = 11'(GOAL_Y_RED);
    localparam logic signed [10:0] YB = 11'(GOAL_Y_BLUE);

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_HOLD, S_OVER} state_t;

    state_t        state_q;
    logic [CW-1:0] hold_cnt_q;
    logic [3:0]    score1_q, score2_q;
    logic [3:0]    score1_d, score2_d;
    logic          goal1_q, goal2_q, over_q;
    logic [1:0]    winner_q;
    logic          in_red, in_blue;

    function automatic logic in_hoop(input logic [9:0] x, input logic [9:0] y,
                                     input logic signed [10:0] cx,
                                     input logic signed [10:0] cy);
        logic signed [10:0] dx, dy;
        logic signed [21:0] dxw, dyw;
        logic [21:0]        sx, sy;
        logic [22:0]        sum;
        dx  = $signed({1'b0, x}) - cx;
        dy  = $signed({1'b0, y}) - cy;
        dxw = 22'(dx);
        dyw = 22'(dy);
        sx  = $unsigned(dxw * dxw);
        sy  = $unsigned(dyw * dyw);
        sum = {1'b0, sx} + {1'b0, sy};
        return sum < THRESH;
    endfunction

    assign in_red  = in_hoop(ball_x, ball_y, X0, YR) | in_hoop(ball_x, ball_y, X1, YR)
                   | in_hoop(ball_x, ball_y, X2, YR);
    assign in_blue = in_hoop(ball_x, ball_y, X0, YB) | in_hoop(ball_x, ball_y, X1, YB)
                   | in_hoop(ball_x, ball_y, X2, YB);

    assign score1_d = score1_q + 4'd1;
    assign score2_d = score2_q + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            hold_cnt_q <= '0;
            score1_q   <= 4'd0;
            score2_q   <= 4'd0;
            goal1_q    <= 1'b0;
            goal2_q    <= 1'b0;
            over_q     <= 1'b0;
            winner_q   <= 2'b00;
        end else begin
            goal1_q <= 1'b0;
            goal2_q <= 1'b0;
            if (new_game) begin
                state_q    <= S_IDLE;
                hold_cnt_q <= '0;
                score1_q   <= 4'd0;
                score2_q   <= 4'd0;
                over_q     <= 1'b0;
                winner_q   <= 2'b00;
            end else begin
                case (state_q)
                    S_IDLE: if (game_on) state_q <= S_PLAY;
                    S_PLAY: begin
                        // Blue row wins a simultaneous hit; pausing play suppresses scoring.
                        if (!game_on) begin
                            state_q <= S_IDLE;
                        end else if (in_blue) begin
                            score2_q <= score2_d;
                            goal2_q  <= 1'b1;
                            if (score2_d == WIN) begin
                                state_q  <= S_OVER;
                                over_q   <= 1'b1;
                                winner_q <= 2'b10;
                            end else begin
                                state_q    <= S_HOLD;
                                hold_cnt_q <= HOLD_LOAD;
                            end
                        end else if (in_red) begin
                            score1_q <= score1_d;
                            goal1_q  <= 1'b1;
                            if (score1_d == WIN) begin
                                state_q  <= S_OVER;
                                over_q   <= 1'b1;
                                winner_q <= 2'b01;
                            end else begin
                                state_q    <= S_HOLD;
                                hold_cnt_q <= HOLD_LOAD;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (!game_on) begin
                            state_q <= S_IDLE;
                        end else if (hold_cnt_q != '0) begin
                            hold_cnt_q <= hold_cnt_q - CW'(1);
                        end else if (!in_red && !in_blue) begin
                            state_q <= S_PLAY;
                        end
                    end
                    S_OVER: state_q <= S_OVER;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign score_team1 = score1_q;
    assign score_team2 = score2_q;
    assign goal_team1  = goal1_q;
    assign goal_team2  = goal2_q;
    assign game_over   = over_q;
    assign winner      = winner_q;
endmodule

// File: tb/tb_goal_referee.sv
// tb/tb_goal_referee.sv - scoreboard bench for goal_referee with a time-based reference model
module tb_goal_referee;
    localparam int HOLD      = 1000;
    localparam int WIN       = 5;
    localparam int THR       = (30 - 10) * (30 - 10);
    localparam int Y_RED     = 100;
    localparam int Y_BLUE    = 450;
    localparam int FAR_X     = 463;
    localparam int FAR_Y     = 275;
    localparam int P_IDLE    = 0;
    localparam int P_PLAY    = 1;
    localparam int P_HOLD    = 2;
    localparam int P_OVER    = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] ball_x, ball_y;
    logic       game_on, new_game;
    logic [3:0] score_team1, score_team2;
    logic       goal_team1, goal_team2, game_over;
    logic [1:0] winner;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_n   = 0;

    int m_phase, m_s1, m_s2, m_win, m_hold_end;
    bit m_g1, m_g2, m_over;
    logic [12:0] exp_q[$];

    goal_referee dut (
        .clk(clk), .rst_n(rst_n), .ball_x(ball_x), .ball_y(ball_y),
        .game_on(game_on), .new_game(new_game),
        .score_team1(score_team1), .score_team2(score_team2),
        .goal_team1(goal_team1), .goal_team2(goal_team2),
        .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] dut_outs();
        return {score_team1, score_team2, goal_team1, goal_team2, game_over, winner};
    endfunction

    task automatic check(input string name, input logic [12:0] got, input logic [12:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s edge=%0d: got s1=%0d s2=%0d g1=%0b g2=%0b over=%0b win=%0b, required s1=%0d s2=%0d g1=%0b g2=%0b over=%0b win=%0b",
                     name, edge_n, got[12:9], got[8:5], got[4], got[3], got[2], got[1:0],
                     exp[12:9], exp[8:5], exp[4], exp[3], exp[2], exp[1:0]);
        end
    endtask

    function automatic bit near(input int x, input int y, input int cx, input int cy);
        return (x - cx) * (x - cx) + (y - cy) * (y - cy) < THR;
    endfunction

    function automatic bit row_hit(input int x, input int y, input int cy);
        return near(x, y, 300, cy) || near(x, y, 400, cy) || near(x, y, 500, cy);
    endfunction

    task automatic award(input int team);
        if (team == 2) begin m_s2++; m_g2 = 1; end
        else           begin m_s1++; m_g1 = 1; end
        if (m_s1 == WIN || m_s2 == WIN) begin
            m_phase = P_OVER;
            m_over  = 1;
            m_win   = team;
        end else begin
            m_phase    = P_HOLD;
            m_hold_end = edge_n + HOLD;
        end
    endtask

    task automatic model_clear();
        m_s1 = 0; m_s2 = 0; m_win = 0; m_over = 0; m_phase = P_IDLE;
    endtask

    // Predicts the outputs after the coming rising edge from the current inputs.
    task automatic model_edge();
        bit red, blue;
        red  = row_hit(int'(ball_x), int'(ball_y), Y_RED);
        blue = row_hit(int'(ball_x), int'(ball_y), Y_BLUE);
        edge_n++;
        m_g1 = 0;
        m_g2 = 0;
        if (!rst_n || new_game) begin
            model_clear();
        end else if (m_phase == P_IDLE) begin
            if (game_on) m_phase = P_PLAY;
        end else if (m_phase == P_PLAY) begin
            if (!game_on)  m_phase = P_IDLE;
            else if (blue) award(2);
            else if (red)  award(1);
        end else if (m_phase == P_HOLD) begin
            if (!game_on) m_phase = P_IDLE;
            else if (edge_n >= m_hold_end && !red && !blue) m_phase = P_PLAY;
        end
        exp_q.push_back({4'(m_s1), 4'(m_s2), m_g1, m_g2, m_over, 2'(m_win)});
    endtask

    task automatic drive(input int x, input int y, input bit on, input bit ng);
        @(negedge clk);
        rst_n    = 1'b1;
        ball_x   = 10'(x);
        ball_y   = 10'(y);
        game_on  = on;
        new_game = ng;
        model_edge();
    endtask

    task automatic far(input int n, input bit on);
        for (int i = 0; i < n; i++) drive(FAR_X, FAR_Y, on, 1'b0);
    endtask

    task automatic score_at(input int x, input int y);
        drive(x, y, 1'b1, 1'b0);
        far(HOLD + 2, 1'b1);
    endtask

    task automatic async_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_reset", dut_outs(), 13'd0);
        model_edge();
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) check("scoreboard", dut_outs(), exp_q.pop_front());
    end

    initial begin
        int on, x, y, r, h;
        rst_n = 1'b0; ball_x = 10'd0; ball_y = 10'd0; game_on = 1'b0; new_game = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #2;
        check("reset_values", dut_outs(), 13'd0);

        far(100, 1'b1);
        drive(300, 450, 1'b1, 1'b0);
        for (int i = 0; i < 5000; i++) drive(300, 450, 1'b1, 1'b0);
        far(20, 1'b1);

        far(3, 1'b1);
        for (int i = 0; i < 3; i++) drive(400, 120, 1'b1, 1'b0);
        score_at(400, 119);

        for (int i = 0; i < 4; i++) score_at(300 + 100 * (i % 3), 100);
        for (int i = 0; i < 20; i++) drive(500, (i % 2) ? 450 : 100, 1'b1, 1'b0);

        drive(FAR_X, FAR_Y, 1'b1, 1'b1);
        far(5, 1'b0);
        far(5, 1'b1);

        score_at(300, 100); score_at(400, 450); score_at(500, 100); score_at(300, 450);
        drive(400, 100, 1'b1, 1'b0);
        far(10, 1'b1);
        async_reset();
        far(2, 1'b0);
        far(2, 1'b1);
        score_at(300, 100); score_at(500, 450); score_at(400, 100);
        far(5, 1'b0);
        drive(300, 100, 1'b0, 1'b0);
        far(2, 1'b1);
        score_at(400, 450);
        drive(300, 100, 1'b1, 1'b0);
        drive(300, 450, 1'b1, 1'b1);
        drive(300, 450, 1'b1, 1'b1);
        far(3, 1'b1);

        on = 1;
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 799) == 0) on = 1 - on;
            r = $urandom_range(0, 99);
            if (r < 30) begin
                h = $urandom_range(0, 5);
                x = 300 + 100 * (h % 3) + $urandom_range(0, 50) - 25;
                y = ((h < 3) ? Y_RED : Y_BLUE) + $urandom_range(0, 50) - 25;
            end else begin
                x = $urandom_range(0, 1023);
                y = $urandom_range(150, 400);
            end
            drive(x, y, on[0], $urandom_range(0, 2999) == 0);
        end

        @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d pending, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
